// File: rtl/ldm_stm_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WB    = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic {
      MODE_IA = 1'b0,
      MODE_DB = 1'b1
   } mode_e;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/ldm_stm_seq_if.sv
// Memory-side request/acknowledge bus of the LDM/STM sequencer.
interface ldm_stm_seq_if #(
   parameter int DATA_W = 32
) ();
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/lowest_set16.sv
// Lowest-set-bit encoder over a 16-bit register mask.
module lowest_set16 (
   input  logic [15:0] vec,
   output logic [3:0]  idx,
   output logic        vld
);
   // Scan downward so the final hit is the lowest set bit.
   always_comb begin
      idx = '0;
      vld = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         if (vec[i]) begin
            idx = 4'(i);
            vld = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM multi-register transfer sequencer; one word access per register, ascending addresses.
// Base-register writeback is built only when LDM_STM_WB_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; latches the transfer description
// ST_ISSUE | one memory access per set mask bit, lowest register first
// ST_WB    | single cycle for the optional base-register writeback
// ST_DONE  | done pulse, then back to idle
module ldm_stm_seq
   import ldm_stm_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_load,
   input  logic              dec_before,
   input  logic              wb_en,
   input  logic [15:0]       reg_list,
   input  logic [3:0]        base_reg,
   input  logic [DATA_W-1:0] base_addr,
   ldm_stm_seq_if.master     mem,
   output logic [3:0]        str_addr,
   input  logic [DATA_W-1:0] str_data,
   output logic              rf_w_en,
   output logic [3:0]        rf_w_addr,
   output logic [DATA_W-1:0] rf_w_data,
   output logic              rf_wb_en,
   output logic [3:0]        rf_wb_addr,
   output logic [DATA_W-1:0] rf_wb_data,
   output logic              busy,
   output logic              done,
   output logic              timeout_err
);

   localparam int                WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
   localparam logic [DATA_W-1:0] STEP     = DATA_W'(WORD_BYTES);

   state_e            state, state_n;
   logic              is_load_q;
   mode_e             mode_q;
   logic [3:0]        base_reg_q;
   logic [DATA_W-1:0] base_addr_q;
   logic [DATA_W-1:0] addr_q;
   logic [15:0]       mask_q;
   logic [4:0]        count_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              wb_allow_q;
   logic              rf_w_en_q;
   logic [3:0]        rf_w_addr_q;
   logic [DATA_W-1:0] rf_w_data_q;

   logic [4:0]        count_in;
   logic [DATA_W-1:0] span_in, span_q;
   logic [3:0]        cur_idx;
   logic              cur_vld;
   logic [15:0]       mask_rest;
   logic              timeout_hit;
   logic              acc_done;
   logic              wb_allow_in;

   lowest_set16 u_pick (
      .vec (mask_q),
      .idx (cur_idx),
      .vld (cur_vld)
   );

   assign count_in    = popcount16(reg_list);
   assign span_in     = DATA_W'(count_in) * STEP;
   assign span_q      = DATA_W'(count_q) * STEP;
   assign mask_rest   = mask_q & ~(16'h0001 << cur_idx);
   // Timeout is taken in the cycle after MAX_WAIT unacknowledged request cycles, with mem_req dropped.
   assign timeout_hit = (MAX_WAIT > 0) && (wait_cnt == WAIT_LIM);
   assign acc_done    = (state == ST_ISSUE) && !timeout_hit && cur_vld && mem.mem_ack;

`ifdef LDM_STM_WB_EN
   // A load that overwrites the base register wins over the writeback.
   assign wb_allow_in = wb_en && !(is_load && reg_list[base_reg]);
`else
   logic unused_wb_en;
   assign unused_wb_en = wb_en;
   assign wb_allow_in  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         is_load_q   <= 1'b0;
         mode_q      <= MODE_IA;
         base_reg_q  <= '0;
         base_addr_q <= '0;
         addr_q      <= '0;
         mask_q      <= '0;
         count_q     <= '0;
         wait_cnt    <= '0;
         wb_allow_q  <= 1'b0;
         rf_w_en_q   <= 1'b0;
         rf_w_addr_q <= '0;
         rf_w_data_q <= '0;
      end else begin
         state     <= state_n;
         rf_w_en_q <= 1'b0;
         if (state == ST_IDLE && start) begin
            is_load_q   <= is_load;
            mode_q      <= mode_e'(dec_before);
            base_reg_q  <= base_reg;
            base_addr_q <= base_addr;
            addr_q      <= dec_before ? (base_addr - span_in) : base_addr;
            mask_q      <= reg_list;
            count_q     <= count_in;
            wait_cnt    <= '0;
            wb_allow_q  <= wb_allow_in;
         end
         if (acc_done) begin
            mask_q   <= mask_rest;
            addr_q   <= addr_q + STEP;
            wait_cnt <= '0;
            if (is_load_q) begin
               rf_w_en_q   <= 1'b1;
               rf_w_addr_q <= cur_idx;
               rf_w_data_q <= mem.mem_rdata;
            end
         end else if (state == ST_ISSUE && !timeout_hit && MAX_WAIT > 0) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_n       = state;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      str_addr      = '0;
      rf_wb_en      = 1'b0;
      rf_wb_addr    = '0;
      rf_wb_data    = '0;
      busy          = (state != ST_IDLE);
      done          = 1'b0;
      timeout_err   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_n = (reg_list == 16'h0000) ? ST_WB : ST_ISSUE;
         end
         ST_ISSUE: begin
            if (timeout_hit) begin
               timeout_err = 1'b1;
               state_n     = ST_DONE;
            end else if (!cur_vld) begin
               state_n = ST_WB;
            end else begin
               mem.mem_req   = 1'b1;
               mem.mem_we    = !is_load_q;
               mem.mem_addr  = addr_q;
               mem.mem_wdata = is_load_q ? '0 : str_data;
               str_addr      = cur_idx;
               if (mem.mem_ack && mask_rest == 16'h0000) state_n = ST_WB;
            end
         end
         ST_WB: begin
            state_n = ST_DONE;
            if (wb_allow_q) begin
               rf_wb_en   = 1'b1;
               rf_wb_addr = base_reg_q;
               rf_wb_data = (mode_q == MODE_DB) ? (base_addr_q - span_q) : (base_addr_q + span_q);
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign rf_w_en   = rf_w_en_q;
   assign rf_w_addr = rf_w_addr_q;
   assign rf_w_data = rf_w_data_q;

endmodule

// File: doc/ldm_stm_seq.md
LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 Parameter: DATA_W, default 32, width of data/address buses.
REQ-002 Parameter: MAX_WAIT, default 0, memory-ack timeout in cycles; 0 disables timeout.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  launch request; sampled only in IDLE.
REQ-006 is_load  in  1  1=LDM, 0=STM.
REQ-007 dec_before  in  1  0=increment-after (IA), 1=decrement-before (DB).
REQ-008 wb_en  in  1  base-register writeback requested.
REQ-009 reg_list  in  16  register mask, bit n = Rn.
REQ-010 base_reg  in  4  base register number.
REQ-011 base_addr  in  DATA_W  base register value.
REQ-012 mem_req/mem_we  out  1/1  memory request, write strobe.
REQ-013 mem_addr/mem_wdata  out  DATA_W  word address, store data.
REQ-014 mem_ack  in  1  request completion; mem_rdata  in  DATA_W  load data, valid with mem_ack.
REQ-015 str_addr  out  4, str_data  in  DATA_W  regfile read port for STM.
REQ-016 rf_w_en/rf_w_addr/rf_w_data  out  1/4/DATA_W  regfile load-data write port.
REQ-017 rf_wb_en/rf_wb_addr/rf_wb_data  out  1/4/DATA_W  regfile base-writeback port.
REQ-018 busy, done, timeout_err  out  1 each  status; done, timeout_err one-cycle pulses.

Function
REQ-019 States SHALL be IDLE, ISSUE, WB, DONE.
REQ-020 IDLE: start=1 SHALL latch all inputs, count=popcount(reg_list), go to ISSUE (or WB if reg_list=0).
REQ-021 Start address SHALL be base_addr (IA) or base_addr-4*count (DB), mod 2^DATA_W; addresses always ascend by 4.
REQ-022 ISSUE: current register = lowest set bit of remaining mask; mem_req=1, mem_addr, mem_we=~is_load, str_addr, mem_wdata=str_data held stable until mem_ack.
REQ-023 On mem_ack: clear that bit, address+=4; if mask now empty go to WB, else stay in ISSUE with next register the following cycle (one access per cycle at zero wait).
REQ-024 LDM: mem_rdata SHALL be registered on ack; rf_w_en=1 with rf_w_addr/rf_w_data exactly one cycle after ack.
REQ-025 WB: one cycle; rf_wb_en=1 iff wb_en and not (is_load and base_reg in reg_list); rf_wb_data=base_addr+4*count (IA) or base_addr-4*count (DB).
REQ-026 DONE: done=1 for one cycle, then IDLE.
REQ-027 busy=1 in ISSUE, WB, DONE; 0 in IDLE.
REQ-028 start while not IDLE SHALL be ignored.
REQ-029 MAX_WAIT>0 and no ack for MAX_WAIT consecutive ISSUE cycles: timeout_err pulse, drop mem_req, skip WB, go to DONE.
REQ-030 Empty reg_list: no memory access; WB then DONE.

Reset
REQ-031 rst SHALL force IDLE and all outputs 0 next cycle, aborting any transfer with no further regfile writes.

Configuration
REQ-032 Macro LDM_STM_WB_EN defined: REQ-025 applies; undefined: rf_wb_en tied 0, wb_en ignored, WB state still occupies one cycle.

Structure
REQ-033 Package ldm_stm_pkg SHALL hold the state enum, WORD_BYTES=4, and the IA/DB mode typedef.
REQ-034 Sub-module lowest_set16 (16-bit lowest-set-bit encoder, index + valid) SHALL select the next register.

Verification
REQ-035 STM IA, list=0x000F, base=0x100, ack same cycle: addresses 0x100,0x104,0x108,0x10C on 4 consecutive cycles, str_addr 0..3, done 6 cycles after start.
REQ-036 LDM DB, list=0x8011, base=0x200, wb_en=1: addresses 0x1F4,0x1F8,0x1FC; writes R0,R4,R15; rf_wb_data=0x1F4 to base_reg.
REQ-037 LDM IA, base_reg=2, list=0x0004, wb_en=1: rf_w_en to R2 with load data, rf_wb_en stays 0.
REQ-038 ack delayed 3 cycles per access: mem_addr/mem_wdata stable throughout; start pulsed mid-transfer ignored.
REQ-039 rst asserted during second access of a 4-register LDM: next cycle busy=0, mem_req=0, no further rf_w_en.
REQ-040 MAX_WAIT=4, ack never given: timeout_err after 4 ISSUE cycles, done next cycle, rf_wb_en never 1.
